a2d_spi_resp: RTL

// - SPI responder (slave) modelling the 8-ch 12-bit A2D seen by the A2D interface master.
// - Decodes channel from a 16-bit command; returns that channel's sample on the NEXT frame.
// - Sits in A2D testbenches/FPGA emulation, fed by battery/current/brake/torque sources.
// - All SPI pins oversampled by clk; SCLK must be <= clk/8.

---
 rtl/a2d_spi_resp_if.sv | 29 ++
 rtl/a2d_spi_resp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/a2d_spi_resp_if.sv
//------------------------------------------------------------------------------
// a2d_spi_resp_if
//   SPI pin bundle between an A2D interface master and the A2D responder model.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface a2d_spi_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  wire  MISO;

  modport master (
    output SS_n,
    output SCLK,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SS_n,
    input  SCLK,
    input  MOSI,
    output MISO
  );
endinterface

`default_nettype wire

// File: rtl/a2d_spi_resp.sv
//------------------------------------------------------------------------------
// a2d_spi_resp
//   Mode-0 SPI responder modelling an 8-channel 12-bit A2D: each frame's reply
//   is the sample for the channel named by the previous complete command.
//   Optional: define SPI_RESP_ERR_EN for frame_err / err_cnt outputs.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module a2d_spi_resp #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic          clk,
  input  wire logic          rst,
  a2d_spi_resp_if.slave      spi,
  input  wire logic [95:0]   ch_data,
  output logic      [15:0]   cmd,
  output logic      [2:0]    ch,
  output logic               cmd_vld
`ifdef SPI_RESP_ERR_EN
  ,
  output logic               frame_err,
  output logic      [7:0]    err_cnt
`endif
);

  localparam logic [4:0] c_frame_bits = 5'd16;
  localparam logic [4:0] c_bit_sat    = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;

  logic [SYNC_STAGES-1:0]   r_ss_sync;
  logic [SYNC_STAGES-1:0]   r_sclk_sync;
  logic [SYNC_STAGES-1:0]   r_mosi_sync;
  logic                     r_sclk_prev;
  logic                     r_armed;

  logic [15:0]              r_rx_shft;
  logic [15:0]              r_tx_shft;
  logic [15:0]              r_rsp_word;
  logic [4:0]               r_bit_cnt;
  logic [15:0]              r_cmd;
  logic [2:0]               r_ch;
  logic                     r_cmd_vld;

  logic                     w_ss_s;
  logic                     w_sclk_s;
  logic                     w_mosi_s;
  logic                     w_sclk_rise;
  logic                     w_sclk_fall;
  logic                     w_start;
  logic                     w_end;
  logic                     w_frame_ok;
  logic                     w_frame_bad;
  logic                     w_shift_act;
  logic [2:0]               w_ch_new;
  logic [11:0]              w_sample;

  // Synchronisers reset low so a frame already in progress at reset release
  // cannot arm the responder until SS_n is genuinely seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ss_sync   <= '0;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0],   spi.SS_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
      r_sclk_prev <= w_sclk_s;
    end
  end

  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // IDLE tests the SS_n level, so a select that fell during DONE still starts.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_ss_s) begin
          w_next  = ST_SHIFT;
          w_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_ss_s) begin
          w_next = ST_DONE;
          w_end  = 1'b1;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_frame_ok  = w_end && (r_bit_cnt == c_frame_bits);
  assign w_frame_bad = w_end && (r_bit_cnt != c_frame_bits);
  assign w_shift_act = (r_state == ST_SHIFT) && !w_ss_s;
  assign w_ch_new    = r_rx_shft[13:11];

  always_comb begin
    w_sample = 12'h000;
    for (int i = 0; i < 8; i++) begin
      if ((w_ch_new == 3'(i)) && (i < NUM_CH)) begin
        w_sample = ch_data[12*i +: 12];
      end
    end
  end

  // Command capture happens on the clock that enters DONE so cmd and cmd_vld
  // become visible together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed    <= 1'b0;
      r_rx_shft  <= 16'h0000;
      r_tx_shft  <= 16'h0000;
      r_rsp_word <= 16'h0000;
      r_bit_cnt  <= 5'd0;
      r_cmd      <= 16'h0000;
      r_ch       <= 3'd0;
      r_cmd_vld  <= 1'b0;
    end else begin
      if (w_ss_s) begin
        r_armed <= 1'b1;
      end
      r_cmd_vld <= w_frame_ok;
      if (w_start) begin
        r_tx_shft <= r_rsp_word;
        r_bit_cnt <= 5'd0;
      end else if (w_shift_act) begin
        if (w_sclk_rise) begin
          r_rx_shft <= {r_rx_shft[14:0], w_mosi_s};
          if (r_bit_cnt != c_bit_sat) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end else if (w_sclk_fall) begin
          r_tx_shft <= {r_tx_shft[14:0], 1'b0};
        end
      end
      if (w_frame_ok) begin
        r_cmd      <= r_rx_shft;
        r_ch       <= w_ch_new;
        r_rsp_word <= {4'h0, w_sample};
      end
    end
  end

`ifdef SPI_RESP_ERR_EN
  logic       r_frame_err;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= 8'h00;
    end else if (w_frame_bad) begin
      r_frame_err <= 1'b1;
      if (r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'h01;
      end
    end
  end

  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;
`else
  logic w_unused_bad;
  assign w_unused_bad = w_frame_bad;
`endif

  assign spi.MISO = ((r_state == ST_SHIFT) && !rst) ? r_tx_shft[15] : 1'bz;
  assign cmd      = r_cmd;
  assign ch       = r_ch;
  assign cmd_vld  = r_cmd_vld;

endmodule

`default_nettype wire
